// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the ALU command issuer.
// Ports: cmd_* (command in), alu_* (to/from ALU), rsp_* (response out).
// master = issuer side, slave = command source / ALU / response consumer side.
interface alu_cmd_issuer_if #(
    parameter int WIDTH = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;

    logic [2:0]         alu_control;
    logic [WIDTH-1:0]   alu_in_data1;
    logic [WIDTH-1:0]   alu_in_data2;
    logic [2*WIDTH-1:0] alu_out_data;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_data;
    logic               rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out_data, rsp_ready,
        output cmd_ready, alu_control, alu_in_data1, alu_in_data2,
               rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out_data, rsp_ready,
        input  cmd_ready, alu_control, alu_in_data1, alu_in_data2,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Purpose: issues one command at a time to a combinational ALU, waits SETTLE cycles, returns the result.
// Latency: result valid SETTLE+1 edges after command accept; illegal opcodes answered 0 edges after accept.
// Backpressure: one op in flight; cmd_ready low until the response is taken (rsp_valid && rsp_ready).
// Ports: clk, rst (sync active-high), bus (alu_cmd_issuer_if.master), busy, op_count, chk_err.
// Optional macro ALU_CHECK_EN: golden-model comparison at capture drives sticky chk_err (else tied 0).
module alu_cmd_issuer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             chk_err
);
    // Counter must hold SETTLE itself; keep at least one bit for SETTLE=0.
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      settle_cnt;
    logic               op_legal;
    logic               accept_legal;
    logic               accept_illegal;
    logic               capture;
    logic               rsp_done;
    logic               cmd_ready_c;

    logic [2:0]         ctl_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               rsp_valid_q;
    logic [2*WIDTH-1:0] rsp_data_q;
    logic               rsp_err_q;

    assign op_legal = (bus.cmd_op <= 3'd4);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        rsp_done       = 1'b0;
        cmd_ready_c    = 1'b0;
        case (state)
            S_IDLE: begin
                // Ready is withheld during reset so nothing is taken that reset will discard.
                cmd_ready_c = ~rst;
                if (bus.cmd_valid && cmd_ready_c) begin
                    if (op_legal) begin
                        accept_legal = 1'b1;
                        state_nxt    = S_SETTLE;
                    end else begin
                        accept_illegal = 1'b1;
                        state_nxt      = S_RESP;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            settle_cnt  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            op_count    <= '0;
        end else begin
            // ALU inputs change only on a legal accept and otherwise keep the last issued op.
            if (accept_legal) begin
                ctl_q      <= bus.cmd_op;
                a_q        <= bus.cmd_a;
                b_q        <= bus.cmd_b;
                settle_cnt <= SW'(SETTLE);
            end else if (state == S_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SW'(1);
            end

            if (accept_illegal) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
            end else if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.alu_out_data;
                rsp_err_q   <= 1'b0;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                if (!rsp_err_q) op_count <= op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_CHECK_EN
    // Expected ALU contract: add/sub/nor/nand in the low WIDTH bits, mult full width.
    function automatic logic [2*WIDTH-1:0] golden(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] r;
        r = '0;
        case (op)
            3'd0:    r = {{WIDTH{1'b0}}, a + b};
            3'd1:    r = {{WIDTH{1'b0}}, a - b};
            3'd2:    r = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            3'd3:    r = {{WIDTH{1'b0}}, ~(a | b)};
            3'd4:    r = {{WIDTH{1'b0}}, ~(a & b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            chk_err <= 1'b0;
        else if (capture && (bus.alu_out_data != golden(ctl_q, a_q, b_q)))
            chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif

    assign busy             = (state != S_IDLE);
    assign bus.cmd_ready    = cmd_ready_c;
    assign bus.alu_control  = ctl_q;
    assign bus.alu_in_data1 = a_q;
    assign bus.alu_in_data2 = b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (SETTLE=1 and SETTLE=0) sharing one stimulus path.
// A transaction-level reference model supplies expected results, latency and op counts.
// Build with or without ALU_CHECK_EN; chk_err expectations follow the macro.
module tb_alu_cmd_issuer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // sel=0 -> SETTLE=1 instance, sel=1 -> SETTLE=0 instance
    logic       sel;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       rsp_ready;
    logic       stuck;

    alu_cmd_issuer_if #(.WIDTH(4)) bus_s1();
    alu_cmd_issuer_if #(.WIDTH(4)) bus_s0();

    logic       busy_s1, busy_s0, chk_s1, chk_s0;
    logic [7:0] cnt_s1, cnt_s0;

    alu_cmd_issuer #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) u_dut_s1 (
        .clk(clk), .rst(rst), .bus(bus_s1), .busy(busy_s1), .op_count(cnt_s1), .chk_err(chk_s1));
    alu_cmd_issuer #(.WIDTH(4), .SETTLE(0), .CNT_W(8)) u_dut_s0 (
        .clk(clk), .rst(rst), .bus(bus_s0), .busy(busy_s0), .op_count(cnt_s0), .chk_err(chk_s0));

    // Reference ALU behaviour in plain integer arithmetic.
    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = (ia + ib) % 16;
            3'd1:    r = (ia - ib + 16) % 16;
            3'd2:    r = ia * ib;
            3'd3:    r = 15 - (ia | ib);
            3'd4:    r = 15 - (ia & ib);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    assign bus_s1.cmd_valid    = cmd_valid & ~sel;
    assign bus_s1.cmd_op       = cmd_op;
    assign bus_s1.cmd_a        = cmd_a;
    assign bus_s1.cmd_b        = cmd_b;
    assign bus_s1.rsp_ready    = rsp_ready & ~sel;
    assign bus_s1.alu_out_data = ref_result(bus_s1.alu_control, bus_s1.alu_in_data1, bus_s1.alu_in_data2)
                                 | {7'd0, stuck};
    assign bus_s0.cmd_valid    = cmd_valid & sel;
    assign bus_s0.cmd_op       = cmd_op;
    assign bus_s0.cmd_a        = cmd_a;
    assign bus_s0.cmd_b        = cmd_b;
    assign bus_s0.rsp_ready    = rsp_ready & sel;
    assign bus_s0.alu_out_data = ref_result(bus_s0.alu_control, bus_s0.alu_in_data1, bus_s0.alu_in_data2);

    logic       o_cmd_ready, o_rsp_valid, o_rsp_err, o_busy, o_chk;
    logic [2:0] o_ctl;
    logic [3:0] o_d1, o_d2;
    logic [7:0] o_rsp_data, o_cnt;

    always_comb begin
        if (sel) begin
            o_cmd_ready = bus_s0.cmd_ready;   o_rsp_valid = bus_s0.rsp_valid;
            o_rsp_err   = bus_s0.rsp_err;     o_rsp_data  = bus_s0.rsp_data;
            o_ctl       = bus_s0.alu_control; o_d1 = bus_s0.alu_in_data1; o_d2 = bus_s0.alu_in_data2;
            o_busy      = busy_s0;            o_cnt = cnt_s0;             o_chk = chk_s0;
        end else begin
            o_cmd_ready = bus_s1.cmd_ready;   o_rsp_valid = bus_s1.rsp_valid;
            o_rsp_err   = bus_s1.rsp_err;     o_rsp_data  = bus_s1.rsp_data;
            o_ctl       = bus_s1.alu_control; o_d1 = bus_s1.alu_in_data1; o_d2 = bus_s1.alu_in_data2;
            o_busy      = busy_s1;            o_cnt = cnt_s1;             o_chk = chk_s1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt [2];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full command/response transaction on the instance picked by s.
    task automatic do_txn(input logic s, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input logic pulse);
        logic [2:0] pc;
        logic [3:0] pa, pb;
        logic [7:0] exp;
        logic       legal;
        int         k, exp_lat;
        sel = s;
        #1;
        pc = o_ctl; pa = o_d1; pb = o_d2;
        legal = (op <= 3'd4);
        chk_val("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        cyc();
        cmd_valid = 1'b0;
        chk_val("busy_after_accept", 32'(o_busy), 32'd1);
        chk_val("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
        if (legal) begin
            exp = ref_result(op, a, b) | ((!s && stuck) ? 8'd1 : 8'd0);
            chk_val("alu_control", 32'(o_ctl), 32'(op));
            chk_val("alu_in_data1", 32'(o_d1), 32'(a));
            chk_val("alu_in_data2", 32'(o_d2), 32'(b));
            exp_lat = s ? 1 : 2;
        end else begin
            exp = 8'd0;
            chk_val("alu_control_kept", 32'(o_ctl), 32'(pc));
            chk_val("alu_in_data1_kept", 32'(o_d1), 32'(pa));
            chk_val("alu_in_data2_kept", 32'(o_d2), 32'(pb));
            exp_lat = 0;
        end
        k = 0;
        while (!o_rsp_valid && k < 20) begin
            cyc();
            k++;
        end
        chk_val("rsp_latency", 32'(k), 32'(exp_lat));
        chk_val("rsp_data", 32'(o_rsp_data), 32'(exp));
        chk_val("rsp_err", 32'(o_rsp_err), 32'(!legal));
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1;
            end
            cyc();
            cmd_valid = 1'b0;
            chk_val("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
            chk_val("hold_rsp_data", 32'(o_rsp_data), 32'(exp));
            chk_val("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        if (legal) exp_cnt[s] = (exp_cnt[s] + 1) % 256;
        chk_val("rsp_valid_cleared", 32'(o_rsp_valid), 32'd0);
        chk_val("cmd_ready_back", 32'(o_cmd_ready), 32'd1);
        chk_val("busy_idle", 32'(o_busy), 32'd0);
        chk_val("op_count", 32'(o_cnt), 32'(exp_cnt[s]));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_val({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd0);
        chk_val({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk_val({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        chk_val({tag, "_rsp_data"}, 32'(o_rsp_data), 32'd0);
        chk_val({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
        chk_val({tag, "_alu"}, {20'd0, o_ctl, o_d1, o_d2}, 32'd0);
        chk_val({tag, "_op_count"}, 32'(o_cnt), 32'd0);
        chk_val({tag, "_chk_err"}, 32'(o_chk), 32'd0);
    endtask

    initial begin
        int exp_chk;
`ifdef ALU_CHECK_EN
        exp_chk = 1;
`else
        exp_chk = 0;
`endif
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0; stuck = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        cyc(); cyc();
        chk_reset_state("reset_s1");
        sel = 1'b1; #1;
        chk_reset_state("reset_s0");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_val("cmd_ready_after_reset", 32'(o_cmd_ready), 32'd1);
        @(negedge clk);

        // Directed cases on SETTLE=1
        do_txn(1'b0, 3'd0, 4'd7, 4'd5, 0, 1'b0);      // 0C
        do_txn(1'b0, 3'd2, 4'd15, 4'd15, 0, 1'b0);    // E1
        do_txn(1'b0, 3'd1, 4'd3, 4'd5, 0, 1'b0);      // 0E
        do_txn(1'b0, 3'd4, 4'd15, 4'd15, 0, 1'b0);    // 00
        do_txn(1'b0, 3'd6, 4'd9, 4'd9, 0, 1'b0);      // illegal
        do_txn(1'b0, 3'd3, 4'd1, 4'd2, 5, 1'b1);      // backpressure + dropped cmd
        // SETTLE=0
        do_txn(1'b1, 3'd0, 4'd1, 4'd1, 0, 1'b0);      // 02
        do_txn(1'b1, 3'd7, 4'd2, 4'd3, 2, 1'b1);

        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset while in SETTLE: pending result discarded
        sel = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 4'd3; cmd_b = 4'd4;
        cyc();
        cmd_valid = 1'b0;
        chk_val("in_settle_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        cyc();
        chk_reset_state("mid_reset");
        rst = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_val("no_rsp_after_reset", 32'(o_rsp_valid), 32'd0);
        end

        // Stuck-at-1 ALU bit0 on SETTLE=1 instance
        stuck = 1'b1;
        do_txn(1'b0, 3'd0, 4'd2, 4'd2, 0, 1'b0);      // captured 05
        chk_val("chk_err_set", 32'(o_chk), 32'(exp_chk));
        stuck = 1'b0;
        do_txn(1'b0, 3'd2, 4'd3, 4'd3, 0, 1'b0);
        chk_val("chk_err_sticky", 32'(o_chk), 32'(exp_chk));
        sel = 1'b1; #1;
        chk_val("chk_err_other_inst", 32'(o_chk), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_val("chk_err_cleared", 32'(o_chk), 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
